warp_dispatcher: RTL

WARP_DISPATCHER -- requirements
Module: warp_dispatcher

---
 rtl/warp_dispatcher.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/warp_dispatcher.sv
// Warp dispatcher: round-robin intake of kernel launch requests into a FIFO,
// warp-ID allocation and a held dispatch offer toward the SIMD core.
module warp_dispatcher #(
  parameter  int NUM_CORES   = 4,
  parameter  int THREAD_W    = 4,
  parameter  int PC_W        = 32,
  parameter  int QUEUE_DEPTH = 8,
  parameter  int NUM_WARPS   = 16,
  localparam int WID_W       = $clog2(NUM_WARPS),
  localparam int QC_W        = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req_valid,
  output logic [NUM_CORES-1:0]          req_ready,
  input  logic [NUM_CORES*THREAD_W-1:0] req_threads,
  input  logic [NUM_CORES*PC_W-1:0]     req_pc,
  output logic                          disp_valid,
  input  logic                          disp_ready,
  output logic [THREAD_W-1:0]           disp_threads,
  output logic [PC_W-1:0]               disp_pc,
  output logic [WID_W-1:0]              disp_wid,
  input  logic                          retire_valid,
  input  logic [WID_W-1:0]              retire_wid,
  output logic                          retire_err,
  output logic [QC_W-1:0]               queue_count,
  output logic [WID_W:0]                busy_count
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int EW = THREAD_W + PC_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [PW-1:0]        rr_ptr_r;
  logic [PW-1:0]        scan_s, grant_idx_s;
  logic                 found_s, full_s, hs_s, enq_s, load_s;
  logic [THREAD_W-1:0]  thr_a [NUM_CORES];
  logic [PC_W-1:0]      pc_a  [NUM_CORES];
  logic [EW-1:0]        mem_r [QUEUE_DEPTH];
  logic [EW-1:0]        head_s;
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [QC_W-1:0]      count_r;
  logic [NUM_WARPS-1:0] busy_r, busy_s, alloc_mask_s, clr_mask_s;
  logic                 free_any_s, ret_hit_s, ret_miss_s;
  logic [WID_W-1:0]     free_wid_s;
  logic [WID_W:0]       busy_count_r;
  logic [THREAD_W-1:0]  disp_threads_r;
  logic [PC_W-1:0]      disp_pc_r;
  logic [WID_W-1:0]     disp_wid_r;
  logic                 retire_err_r;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_unpack
    assign thr_a[c] = req_threads[c*THREAD_W +: THREAD_W];
    assign pc_a[c]  = req_pc[c*PC_W +: PC_W];
  end

  // Round-robin scan: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    scan_s      = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_s      = PW'((int'(rr_ptr_r) + i) % NUM_CORES);
      grant_idx_s = (!found_s && req_valid[scan_s]) ? scan_s : grant_idx_s;
      found_s     = found_s | req_valid[scan_s];
    end
  end

  // A full FIFO refuses intake even when the head leaves this same cycle.
  assign full_s    = (count_r == QC_W'(QUEUE_DEPTH));
  assign hs_s      = found_s & ~full_s;
  assign req_ready = hs_s ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << grant_idx_s) : '0;
  assign enq_s     = hs_s & (thr_a[grant_idx_s] != '0);
  assign head_s    = mem_r[rd_ptr_r];

  // Lowest free warp ID, taken from the busy set as it stood before this edge.
  always_comb begin
    free_any_s = 1'b0;
    free_wid_s = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      free_wid_s = (!free_any_s && !busy_r[w]) ? WID_W'(w) : free_wid_s;
      free_any_s = free_any_s | ~busy_r[w];
    end
  end

  assign load_s       = (count_r != '0) & free_any_s & ((state_r == IDLE) | disp_ready);
  assign ret_hit_s    = retire_valid & busy_r[retire_wid];
  assign ret_miss_s   = retire_valid & ~busy_r[retire_wid];
  assign alloc_mask_s = load_s    ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << free_wid_s) : '0;
  assign clr_mask_s   = ret_hit_s ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << retire_wid) : '0;
  assign busy_s       = (busy_r | alloc_mask_s) & ~clr_mask_s;

  // Dispatch FSM next state; an accepted offer is immediately replaced when possible.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = load_s ? OFFER : IDLE;
      OFFER:   state_s = (disp_ready && !load_s) ? IDLE : OFFER;
      default: state_s = IDLE;
    endcase
  end

  // State, pointers, occupancy, busy set and the registered offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      rr_ptr_r       <= '0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      busy_r         <= '0;
      busy_count_r   <= '0;
      disp_threads_r <= '0;
      disp_pc_r      <= '0;
      disp_wid_r     <= '0;
      retire_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (hs_s) begin
        rr_ptr_r <= (grant_idx_s == PW'(NUM_CORES - 1)) ? '0 : grant_idx_s + PW'(1'b1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      wr_ptr_r     <= enq_s  ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
      rd_ptr_r     <= load_s ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
      count_r      <= count_r + QC_W'(enq_s) - QC_W'(load_s);
      busy_r       <= busy_s;
      busy_count_r <= busy_count_r + (WID_W+1)'(load_s) - (WID_W+1)'(ret_hit_s);
      retire_err_r <= ret_miss_s;
      if (load_s) begin
        disp_threads_r <= head_s[EW-1 -: THREAD_W];
        disp_pc_r      <= head_s[PC_W-1:0];
        disp_wid_r     <= free_wid_s;
      end else begin
        disp_threads_r <= disp_threads_r;
        disp_pc_r      <= disp_pc_r;
        disp_wid_r     <= disp_wid_r;
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[wr_ptr_r] <= {thr_a[grant_idx_s], pc_a[grant_idx_s]};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign disp_valid   = (state_r == OFFER);
  assign disp_threads = disp_threads_r;
  assign disp_pc      = disp_pc_r;
  assign disp_wid     = disp_wid_r;
  assign retire_err   = retire_err_r;
  assign queue_count  = count_r;
  assign busy_count   = busy_count_r;

endmodule
